// File: rtl/reg_file_sb.sv
// Register file with a per-register pending-write scoreboard for the LC-3b pipeline.
// Optional same-cycle writeback-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dr,
  output logic              issue_stall,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0] mem  [NUM_REGS];
  logic [PEND_W-1:0] pend [NUM_REGS];

  logic [PEND_W-1:0] pend_issue;
  logic [PEND_W-1:0] pend_wr;
  logic [PEND_W-1:0] pend_rd1;
  logic [PEND_W-1:0] pend_rd2;
  logic              issue_wb_same;
  logic              issue_acc;
  logic [NUM_REGS-1:0] pend_inc;
  logic [NUM_REGS-1:0] pend_wb;

  assign pend_issue = pend[issue_dr];
  assign pend_wr    = pend[wr_addr];
  assign pend_rd1   = pend[rd_addr1];
  assign pend_rd2   = pend[rd_addr2];

  // A full counter can still take a reservation if a retiring writeback frees a slot this cycle.
  assign issue_wb_same = we && (wr_addr == issue_dr);
  assign issue_stall   = issue_valid && (pend_issue == PEND_MAX)
                         && !(issue_wb_same && (pend_issue != '0));
  assign issue_acc     = issue_valid && !issue_stall;

  always_comb begin
    pend_inc = '0;
    pend_wb  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_inc[i] = issue_acc && (issue_dr == ADDR_W'(i));
      pend_wb[i]  = we && (wr_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i]  <= '0;
        pend[i] <= '0;
      end
      wr_err <= 1'b0;
    end else begin
      if (we) begin
        mem[wr_addr] <= wr_data;
      end
      wr_err <= we && (pend_wr == '0);
      // Issue and writeback to the same register cancel out and hold the count.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (pend_inc[i] && !pend_wb[i]) begin
          if (pend[i] != PEND_MAX) begin
            pend[i] <= pend[i] + PEND_ONE;
          end
        end else if (pend_wb[i] && !pend_inc[i]) begin
          if (pend[i] != '0) begin
            pend[i] <= pend[i] - PEND_ONE;
          end
        end
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic byp1;
  logic byp2;

  always_comb begin
    byp1     = we && (wr_addr == rd_addr1);
    byp2     = we && (wr_addr == rd_addr2);
    rd_data1 = byp1 ? wr_data : mem[rd_addr1];
    rd_data2 = byp2 ? wr_data : mem[rd_addr2];
    // The last outstanding write retiring now clears busy, unless a new reservation lands too.
    rd_busy1 = (pend_rd1 != '0)
               && !(byp1 && (pend_rd1 == PEND_ONE) && !(issue_acc && (issue_dr == rd_addr1)));
    rd_busy2 = (pend_rd2 != '0)
               && !(byp2 && (pend_rd2 == PEND_ONE) && !(issue_acc && (issue_dr == rd_addr2)));
  end
`else
  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];
  assign rd_busy1 = (pend_rd1 != '0);
  assign rd_busy2 = (pend_rd2 != '0);
`endif

endmodule
